sram_rr_arbiter: RTL
====================

# sram_rr_arbiter

Parametrised single-clock arbiter that merges NUM_WRITE write-request ports and NUM_READ read-request ports onto one SRAM command interface. It is the successor to the fixed four-port arbiter and sits between the per-port request FIFOs and the SRAM controller. Grant order is work-conserving round-robin or fixed-priority. An in-order tag FIFO routes returned read data to the issuing port. Reads are gated by per-port prog_full and by an outstanding-read limit.

## Interface
- NUM_WRITE, 2: write ports; global indices 0..NUM_WRITE-1
- NUM_READ, 2: read ports; global indices NUM_WRITE..N-1, where N = NUM_WRITE+NUM_READ
- ADDR_WIDTH, 19: SRAM address width
- DATA_WIDTH, 32: SRAM data width
- MASK_WIDTH, 4: write byte-mask width
- MAX_OUTSTANDING, 8: tag FIFO depth, power of 2, ≥2
- MODE, ARB_RR: ARB_RR (round-robin) or ARB_FIXED (lowest index wins)

Ports:
- clock  in  1  single clock, shared by all ports and the SRAM side
- reset_n  in  1  asynchronous, active-low reset
- w_valid  in  NUM_WRITE  write request present
- w_addr / w_data / w_mask  in  NUM_WRITE×(ADDR/DATA/MASK_WIDTH)  packed write request fields
- w_ready  out  NUM_WRITE  one-hot pop strobe for the granted write port
- r_valid  in  NUM_READ  read request present
- r_addr  in  NUM_READ×ADDR_WIDTH  read addresses
- r_ready  out  NUM_READ  one-hot pop strobe for the granted read port
- r_prog_full  in  NUM_READ  read-data FIFO almost full; blocks that port
- r_dout  out  DATA_WIDTH  returned read data, shared by all read ports
- r_dout_valid  out  NUM_READ  one-hot write strobe into the destination read-data FIFO
- sram_addr_valid  out  1  command valid
- sram_ready  in  1  controller accepts the command this cycle
- sram_addr  out  ADDR_WIDTH  command address
- sram_data_in  out  DATA_WIDTH  write data
- sram_write_mask  out  MASK_WIDTH  write mask; all-zero means read
- sram_data_out  in  DATA_WIDTH  read data
- sram_data_out_valid  in  1  read data valid
- state  out  clog2(N)  index of the last granted port (debug)
- rsp_error  out  1  sticky: data returned with no outstanding tag

## Operation
- Eligibility: a write port k is eligible when w_valid[k]=1. A read port k is eligible when r_valid[k]=1, r_prog_full[k]=0, and the tag count is below MAX_OUTSTANDING.
- A grant is issued only in a slot cycle, i.e. a cycle where the command register is empty or sram_ready=1.
- ARB_RR: the search starts at ptr and wraps modulo N. The first eligible port wins. After a grant to port g, ptr becomes (g+1) mod N, so g = N-1 wraps ptr to 0.
- ARB_FIXED: ptr is held at 0.
- The grant pulses the matching w_ready or r_ready for one cycle, loads the command register, and updates state to g.
- A read grant also pushes tag g-NUM_WRITE into the tag FIFO.
- If no port is eligible, the slot is idle: no pop strobe, sram_addr_valid falls to 0, state holds, ptr holds.
- Read return: when sram_data_out_valid=1, the FIFO head tag is popped. r_dout_valid[tag] pulses and r_dout = sram_data_out.
- If sram_data_out_valid=1 with an empty tag FIFO, the data is dropped, rsp_error is set, and it clears only on reset.
- A tag push and a tag pop in the same cycle leave the count unchanged. A full FIFO with a simultaneous pop still blocks that cycle's read grant, because eligibility uses the registered count.
- Reset mid-operation: all outstanding tags are discarded and the command register is cleared.

## Timing
- After reset, every output is 0. ptr=0, state=0, tag count=0.
- Request sampled in cycle t: pop strobe in cycle t (combinational grant), sram_addr_valid in cycle t+1 (registered).
- The command is held stable while sram_addr_valid=1 and sram_ready=0.
- With sram_ready=1 continuously, throughput is one command per cycle.
- Read data to r_dout_valid: 1 cycle (registered).
- A change in r_prog_full takes effect on the same cycle's grant.

## Structure
- Package sram_arb_pkg holds:
  - constants ARB_RR and ARB_FIXED;
  - the function clog2;
  - the packed struct sram_cmd_t {addr, data, mask}.
- Sub-module sram_tag_fifo: synchronous FIFO, width clog2(NUM_READ), depth MAX_OUTSTANDING, with count output.

## Test plan
- Defaults (2W/2R), all four valid, sram_ready=1 -> state sequence 0,1,2,3,0,1,2,3. sram_addr_valid=1 from the second cycle onward.
- Only port 2 valid, then only port 0 -> state=2 for each request. The next grant is 0 with no idle slot in between.
- r_valid=2'b11, r_prog_full=2'b11, writes idle for 64 cycles -> r_ready=0 and sram_addr_valid=0 throughout.
- MAX_OUTSTANDING=8, 10 reads from port 3, no data returned -> exactly 8 grants. Then one sram_data_out_valid with data 0xA5 -> r_dout_valid=2'b10, r_dout=0xA5, and a 9th grant next slot.
- sram_ready=0 for 5 cycles with a write pending -> command held and w_ready pulsed once. Then a spurious sram_data_out_valid with empty tags -> rsp_error=1 until reset_n=0.
- MODE=ARB_FIXED, all four ports valid -> port 0 is granted every slot.

Source files
------------

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared constants, helper function and command record for the
//               SRAM request arbiter and its tag FIFO.
//               Contents:
//                 ARB_RR / ARB_FIXED - arbitration mode selectors
//                 clog2()            - ceil(log2(n)), never less than 1
//                 sram_cmd_t         - {addr, data, mask} command record
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Field widths of the command record. They are upper bounds: the arbiter
  // casts its parameterised buses into and out of these fields.
  localparam int CMD_ADDR_W = 19;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_MASK_W = 4;

  // Returns at least 1 so that single-entry ranges still produce a legal
  // vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_MASK_W-1:0] mask;
  } sram_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sram_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_tag_fifo
// Description : Synchronous FIFO that holds read-port tags in issue order.
//               Ports:
//                 clk_i, rst_ni - clock, asynchronous active-low reset
//                 push_i        - write push_data_i (ignored when full)
//                 pop_i         - discard head entry (ignored when empty)
//                 head_o        - oldest entry
//                 empty_o       - no entries held
//                 count_o       - number of entries held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_rr_arbiter
// Description : Merges NUM_WRITE write ports and NUM_READ read ports onto one
//               SRAM command interface (round-robin or fixed priority) and
//               routes returned read data back to the issuing read port.
//               Ports:
//                 clock, reset_n          - clock, async active-low reset
//                 w_valid/addr/data/mask  - packed write requests
//                 w_ready                 - one-hot write pop strobe
//                 r_valid/r_addr          - packed read requests
//                 r_ready                 - one-hot read pop strobe
//                 r_prog_full             - per read port back-pressure
//                 r_dout, r_dout_valid    - returned data, one-hot strobe
//                 sram_*                  - SRAM controller command/return
//                 state                   - last granted global port index
//                 rsp_error               - sticky: data with no tag
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_WRITE       = 2,
  parameter int NUM_READ        = 2,
  parameter int ADDR_WIDTH      = 19,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MODE            = ARB_RR
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_WRITE-1:0]             w_valid,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  w_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  w_data,
  input  logic [NUM_WRITE*MASK_WIDTH-1:0]  w_mask,
  output logic [NUM_WRITE-1:0]             w_ready,
  input  logic [NUM_READ-1:0]              r_valid,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   r_addr,
  output logic [NUM_READ-1:0]              r_ready,
  input  logic [NUM_READ-1:0]              r_prog_full,
  output logic [DATA_WIDTH-1:0]            r_dout,
  output logic [NUM_READ-1:0]              r_dout_valid,
  output logic                             sram_addr_valid,
  input  logic                             sram_ready,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [DATA_WIDTH-1:0]            sram_data_in,
  output logic [MASK_WIDTH-1:0]            sram_write_mask,
  input  logic [DATA_WIDTH-1:0]            sram_data_out,
  input  logic                             sram_data_out_valid,
  output logic [clog2(NUM_WRITE+NUM_READ)-1:0] state,
  output logic                             rsp_error
);

  localparam int N  = NUM_WRITE + NUM_READ;
  localparam int PW = clog2(N);
  localparam int TW = clog2(NUM_READ);
  localparam int CW = clog2(MAX_OUTSTANDING) + 1;

  logic [N-1:0]          elig;
  logic                  reads_ok;
  logic                  slot;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;
  logic                  issue;
  logic                  is_read;
  int                    cand;
  sram_cmd_t             cmd_d,     cmd_q;
  logic                  cmd_vld_q;
  logic [PW-1:0]         ptr_d,     ptr_q;
  logic [PW-1:0]         state_q;
  logic [NUM_READ-1:0]   rdv_d,     rdv_q;
  logic [DATA_WIDTH-1:0] rdout_q;
  logic                  rsp_err_q;
  logic [TW-1:0]         tag_in;
  logic [TW-1:0]         tag_head;
  logic                  tag_empty;
  logic [CW-1:0]         tag_cnt;
  logic                  tag_push;
  logic                  tag_pop;

  // Registered count: a pop landing in the same cycle does not free a slot
  // for this cycle's read grant.
  assign reads_ok = (tag_cnt < CW'(MAX_OUTSTANDING));

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_WRITE; k++) elig[k] = w_valid[k];
    for (int k = 0; k < NUM_READ; k++)
      elig[NUM_WRITE+k] = r_valid[k] & ~r_prog_full[k] & reads_ok;
  end

  // Slot: the command register is free now or is being consumed this cycle.
  assign slot = ~cmd_vld_q | sram_ready;

  // Rotating search starting at ptr_q; first eligible port wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      for (int k = 0; k < N; k++) begin
        if (!gnt_vld && (cand == k) && elig[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(k);
        end
      end
    end
  end

  assign issue   = slot & gnt_vld;
  assign is_read = (gnt_idx >= PW'(NUM_WRITE));

  always_comb begin
    w_ready = '0;
    r_ready = '0;
    for (int k = 0; k < NUM_WRITE; k++) w_ready[k] = issue && (gnt_idx == PW'(k));
    for (int k = 0; k < NUM_READ; k++)  r_ready[k] = issue && (gnt_idx == PW'(NUM_WRITE + k));
  end

  // Command mux; reads carry zero data and an all-zero mask.
  always_comb begin
    cmd_d  = '0;
    tag_in = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (gnt_idx == PW'(k)) begin
        cmd_d.addr = CMD_ADDR_W'(w_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
        cmd_d.data = CMD_DATA_W'(w_data[k*DATA_WIDTH +: DATA_WIDTH]);
        cmd_d.mask = CMD_MASK_W'(w_mask[k*MASK_WIDTH +: MASK_WIDTH]);
      end
    end
    for (int k = 0; k < NUM_READ; k++) begin
      if (gnt_idx == PW'(NUM_WRITE + k)) begin
        cmd_d.addr = CMD_ADDR_W'(r_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
        tag_in     = TW'(k);
      end
    end
  end

  always_comb begin
    if (MODE == ARB_FIXED)               ptr_d = '0;
    else if (gnt_idx == PW'(N - 1))      ptr_d = '0;
    else                                 ptr_d = gnt_idx + 1'b1;
  end

  assign tag_push = issue & is_read;
  assign tag_pop  = sram_data_out_valid & ~tag_empty;

  always_comb begin
    rdv_d = '0;
    for (int k = 0; k < NUM_READ; k++) rdv_d[k] = tag_pop && (tag_head == TW'(k));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_vld_q <= 1'b0;
      cmd_q     <= '0;
      ptr_q     <= '0;
      state_q   <= '0;
      rdv_q     <= '0;
      rdout_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (slot) begin
        cmd_vld_q <= gnt_vld;
        if (gnt_vld) begin
          cmd_q   <= cmd_d;
          state_q <= gnt_idx;
          ptr_q   <= ptr_d;
        end
      end
      rdv_q <= rdv_d;
      if (tag_pop) rdout_q <= sram_data_out;
      if (sram_data_out_valid && tag_empty) rsp_err_q <= 1'b1;
    end
  end

  sram_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .push_i      (tag_push),
    .push_data_i (tag_in),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .count_o     (tag_cnt)
  );

  assign sram_addr_valid = cmd_vld_q;
  assign sram_addr       = ADDR_WIDTH'(cmd_q.addr);
  assign sram_data_in    = DATA_WIDTH'(cmd_q.data);
  assign sram_write_mask = MASK_WIDTH'(cmd_q.mask);
  assign state           = state_q;
  assign r_dout          = rdout_q;
  assign r_dout_valid    = rdv_q;
  assign rsp_error       = rsp_err_q;

endmodule
`default_nettype wire
